// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a data-memory ready stall.
// Optional MEM abort after TIMEOUT_CYCLES wait cycles when MC_MEM_TIMEOUT_EN is defined.
module mc_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] instr_op,
  input  logic [5:0] instr_funct,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       rf_we,
  output logic       dm_re,
  output logic       dm_we,
  output logic [1:0] regdst,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic [1:0] datasrc,
  output logic [1:0] npc_sel,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    ClsNone, ClsAddu, ClsSubu, ClsSll, ClsJr, ClsOri, ClsLui,
    ClsLw, ClsSw, ClsBeq, ClsJ, ClsJal, ClsIll
  } cls_e;

  state_e state_q;
  cls_e   cls_q;
  cls_e   dec_cls;
  logic   mem_abort;

  if (TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  assign state = state_q;

  always_comb begin
    dec_cls = ClsIll;
    case (instr_op)
      6'b000000: begin
        case (instr_funct)
          6'b100001: dec_cls = ClsAddu;
          6'b100011: dec_cls = ClsSubu;
          6'b000000: dec_cls = ClsSll;
          6'b001000: dec_cls = ClsJr;
          default:   dec_cls = ClsIll;
        endcase
      end
      6'b001101: dec_cls = ClsOri;
      6'b001111: dec_cls = ClsLui;
      6'b100011: dec_cls = ClsLw;
      6'b101011: dec_cls = ClsSw;
      6'b000100: dec_cls = ClsBeq;
      6'b000010: dec_cls = ClsJ;
      6'b000011: dec_cls = ClsJal;
      default:   dec_cls = ClsIll;
    endcase
  end

`ifdef MC_MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wait_cnt_q;

  assign mem_abort = (state_q == StMem) && !mem_ready && (wait_cnt_q == CntW'(TIMEOUT_CYCLES));

  // Held at zero outside MEM, so every MEM entry starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (state_q != StMem) begin
      wait_cnt_q <= '0;
    end else if (!mem_ready && !mem_abort) begin
      wait_cnt_q <= wait_cnt_q + CntW'(1);
    end
  end
`else
  assign mem_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      cls_q   <= ClsNone;
    end else begin
      unique case (state_q)
        StFetch: state_q <= StDecode;
        StDecode: begin
          cls_q <= dec_cls;
          case (dec_cls)
            ClsJ, ClsJr, ClsIll: state_q <= StFetch;
            ClsJal:              state_q <= StWb;
            default:             state_q <= StExec;
          endcase
        end
        StExec: begin
          case (cls_q)
            ClsLw, ClsSw: state_q <= StMem;
            ClsBeq:       state_q <= StFetch;
            default:      state_q <= StWb;
          endcase
        end
        StMem: begin
          if (mem_ready) begin
            state_q <= (cls_q == ClsLw) ? StWb : StFetch;
          end else if (mem_abort) begin
            state_q <= StFetch;
          end
        end
        StWb:    state_q <= StFetch;
        default: state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    pc_we       = 1'b0;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    dm_re       = 1'b0;
    dm_we       = 1'b0;
    regdst      = 2'b00;
    alu_a_sel   = 1'b0;
    alu_b_sel   = 1'b0;
    datasrc     = 2'b00;
    npc_sel     = 2'b00;
    alu_op      = 3'b000;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
        StDecode: begin
          case (dec_cls)
            ClsJ, ClsJal: begin
              pc_we   = 1'b1;
              npc_sel = 2'b01;
            end
            ClsJr: begin
              pc_we   = 1'b1;
              npc_sel = 2'b11;
            end
            ClsIll:  illegal = 1'b1;
            default: ;
          endcase
        end
        StExec: begin
          case (cls_q)
            ClsSubu: alu_op = 3'b001;
            ClsSll: begin
              alu_op    = 3'b100;
              alu_a_sel = 1'b1;
            end
            ClsOri: begin
              alu_op    = 3'b010;
              alu_b_sel = 1'b1;
            end
            ClsLui: begin
              alu_op    = 3'b011;
              alu_b_sel = 1'b1;
            end
            ClsLw, ClsSw: alu_b_sel = 1'b1;
            ClsBeq: begin
              alu_op  = 3'b001;
              pc_we   = 1'b1;
              npc_sel = 2'b10;
            end
            default: ;
          endcase
        end
        StMem: begin
          dm_re       = (cls_q == ClsLw) && !mem_abort;
          dm_we       = (cls_q == ClsSw) && !mem_abort;
          mem_timeout = mem_abort;
        end
        StWb: begin
          rf_we = 1'b1;
          case (cls_q)
            ClsOri, ClsLui: regdst = 2'b01;
            ClsLw: begin
              regdst  = 2'b01;
              datasrc = 2'b01;
            end
            ClsJal: begin
              regdst  = 2'b10;
              datasrc = 2'b10;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: per-instruction expected cycle sequences from a behavioural
// model, compared every cycle on the falling edge.
module tb_mc_ctrl_fsm;

`ifdef MC_MEM_TIMEOUT_EN
  localparam int TO = 4;
  localparam bit HasTimeout = 1'b1;
`else
  localparam int TO = 16;
  localparam bit HasTimeout = 1'b0;
`endif

  localparam int KADDU = 0, KSUBU = 1, KSLL = 2, KJR = 3, KORI = 4, KLUI = 5;
  localparam int KLW = 6, KSW = 7, KBEQ = 8, KJ = 9, KJAL = 10, KILL = 11;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       rf_we;
    logic       dm_re;
    logic       dm_we;
    logic [1:0] regdst;
    logic       alu_a;
    logic       alu_b;
    logic [1:0] datasrc;
    logic [1:0] npc;
    logic [2:0] alu_op;
    logic       illegal;
    logic       mto;
    logic [2:0] st;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [5:0] instr_op;
  logic [5:0] instr_funct;
  logic       mem_ready;
  logic       pc_we, ir_we, rf_we, dm_re, dm_we;
  logic [1:0] regdst, datasrc, npc_sel;
  logic       alu_a_sel, alu_b_sel;
  logic [2:0] alu_op;
  logic       illegal, mem_timeout;
  logic [2:0] state;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t ex_c;
  exp_t got_c;

  logic [5:0] tbl_op [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'b001101, 6'b001111,
                              6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
  logic [5:0] tbl_fn [11] = '{6'b100001, 6'b100011, 6'b000000, 6'b001000, 6'h00, 6'h00,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  mc_ctrl_fsm #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_op    (instr_op),
    .instr_funct (instr_funct),
    .mem_ready   (mem_ready),
    .pc_we       (pc_we),
    .ir_we       (ir_we),
    .rf_we       (rf_we),
    .dm_re       (dm_re),
    .dm_we       (dm_we),
    .regdst      (regdst),
    .alu_a_sel   (alu_a_sel),
    .alu_b_sel   (alu_b_sel),
    .datasrc     (datasrc),
    .npc_sel     (npc_sel),
    .alu_op      (alu_op),
    .illegal     (illegal),
    .mem_timeout (mem_timeout),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ex_c  = exp_q.pop_front();
      got_c = {pc_we, ir_we, rf_we, dm_re, dm_we, regdst, alu_a_sel, alu_b_sel, datasrc,
               npc_sel, alu_op, illegal, mem_timeout, state};
      checks++;
      if (got_c !== ex_c) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, got_c, ex_c);
      end
    end
  end

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b100001) return KADDU;
        if (fn == 6'b100011) return KSUBU;
        if (fn == 6'b000000) return KSLL;
        if (fn == 6'b001000) return KJR;
        return KILL;
      end
      6'b001101: return KORI;
      6'b001111: return KLUI;
      6'b100011: return KLW;
      6'b101011: return KSW;
      6'b000100: return KBEQ;
      6'b000010: return KJ;
      6'b000011: return KJAL;
      default:   return KILL;
    endcase
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs, queue that cycle's expected outputs, then advance.
  task automatic step(input exp_t e, input logic [5:0] op, input logic [5:0] fn,
                      input logic mr, input logic rs);
    reset       = rs;
    instr_op    = op;
    instr_funct = fn;
    mem_ready   = mr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One instruction from FETCH; waits = MEM cycles with ready low; rst_mem resets instead of ready.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int waits,
                           input bit rst_mem, output int len);
    int   k;
    exp_t e;
    k   = classify(op, fn);
    len = 0;
    e = '0; e.pc_we = 1'b1; e.ir_we = 1'b1;
    step(e, rnd6(), rnd6(), rbit(), 1'b0); len++;
    e = '0; e.st = 3'd1;
    if (k == KJ || k == KJAL) begin e.pc_we = 1'b1; e.npc = 2'b01; end
    if (k == KJR) begin e.pc_we = 1'b1; e.npc = 2'b11; end
    if (k == KILL) e.illegal = 1'b1;
    step(e, op, fn, rbit(), 1'b0); len++;
    if (k == KJ || k == KJR || k == KILL) return;
    if (k != KJAL) begin
      e = '0; e.st = 3'd2;
      case (k)
        KSUBU: e.alu_op = 3'b001;
        KSLL:  begin e.alu_op = 3'b100; e.alu_a = 1'b1; end
        KORI:  begin e.alu_op = 3'b010; e.alu_b = 1'b1; end
        KLUI:  begin e.alu_op = 3'b011; e.alu_b = 1'b1; end
        KLW, KSW: e.alu_b = 1'b1;
        KBEQ:  begin e.alu_op = 3'b001; e.pc_we = 1'b1; e.npc = 2'b10; end
        default: ;
      endcase
      step(e, rnd6(), rnd6(), rbit(), 1'b0); len++;
      if (k == KBEQ) return;
      if (k == KLW || k == KSW) begin
        for (int w = 0; w <= waits; w++) begin
          logic mr;
          mr = (w == waits) && !rst_mem;
          if (HasTimeout && w == TO && !mr) begin
            e = '0; e.st = 3'd3; e.mto = 1'b1;
            step(e, rnd6(), rnd6(), 1'b0, 1'b0); len++;
            return;
          end
          if (w == waits && rst_mem) begin
            e = '0;
            step(e, rnd6(), rnd6(), rbit(), 1'b1);
            return;
          end
          e = '0; e.st = 3'd3; e.dm_re = (k == KLW); e.dm_we = (k == KSW);
          step(e, rnd6(), rnd6(), mr, 1'b0); len++;
        end
        if (k == KSW) return;
      end
    end
    e = '0; e.st = 3'd4; e.rf_we = 1'b1;
    case (k)
      KORI, KLUI: e.regdst = 2'b01;
      KLW:  begin e.regdst = 2'b01; e.datasrc = 2'b01; end
      KJAL: begin e.regdst = 2'b10; e.datasrc = 2'b10; end
      default: ;
    endcase
    step(e, rnd6(), rnd6(), rbit(), 1'b0); len++;
  endtask

  initial begin
    int len;
    int r;
    exp_t z;
    z           = '0;
    reset       = 1'b1;
    instr_op    = '0;
    instr_funct = '0;
    mem_ready   = 1'b0;
    @(posedge clk);
    #1;
    step(z, rnd6(), rnd6(), rbit(), 1'b1);
    step(z, rnd6(), rnd6(), rbit(), 1'b1);

    run_instr(6'b000000, 6'b100001, 0, 1'b0, len); chk("addu_len", len, 4);
    run_instr(6'b100011, 6'h00, 3, 1'b0, len);     chk("lw_wait3_len", len, 8);
    run_instr(6'b000011, 6'h00, 0, 1'b0, len);     chk("jal_len", len, 3);
    run_instr(6'b111111, 6'h15, 0, 1'b0, len);     chk("illegal_len", len, 2);
    run_instr(6'b101011, 6'h00, 2, 1'b1, len);     chk("sw_reset_mem_len", len, 5);
    run_instr(6'b101011, 6'h00, 0, 1'b0, len);     chk("sw_len", len, 4);
    run_instr(6'b000100, 6'h00, 0, 1'b0, len);     chk("beq_len", len, 3);
    run_instr(6'b000010, 6'h00, 0, 1'b0, len);     chk("j_len", len, 2);
    run_instr(6'b000000, 6'b001000, 0, 1'b0, len); chk("jr_len", len, 2);
    run_instr(6'b001101, 6'h00, 0, 1'b0, len);     chk("ori_len", len, 4);
    run_instr(6'b101011, 6'h00, 20, 1'b1, len);
    chk("sw_stuck_len", len, HasTimeout ? 8 : 23);
    run_instr(6'b100011, 6'h00, TO, 1'b0, len);    chk("lw_wait_to_len", len, TO + 5);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 12);
      if (r < 11) begin
        run_instr(tbl_op[r], tbl_fn[r], $urandom_range(0, 5), ($urandom_range(0, 19) == 0), len);
      end else if (r == 11) begin
        run_instr(rnd6(), rnd6(), $urandom_range(0, 5), 1'b0, len);
      end else begin
        run_instr(6'h00, rnd6(), $urandom_range(0, 5), 1'b0, len);
      end
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle control sequencer for the single-datapath MIPS core.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives every datapath mux select (RF write address, ALU A/B, RF write data, next PC) and all write enables.
- Stalls in MEM on a data-memory ready handshake.
- Sits between the IR outputs and the datapath; branch resolution stays in the PC mux via its Branch input.

Parameters:
TIMEOUT_CYCLES, 16, maximum MEM wait cycles before abort; used only with MC_MEM_TIMEOUT_EN.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
instr_op  in  6  IR[31:26], valid in DECODE
instr_funct  in  6  IR[5:0], valid in DECODE
mem_ready  in  1  DM handshake: access completes this cycle
pc_we  out  1  PC register write enable
ir_we  out  1  IR write enable
rf_we  out  1  register file write enable
dm_re  out  1  data memory read request
dm_we  out  1  data memory write request
regdst  out  2  00 rd(A3), 01 rt(A2), 10 $31
alu_a_sel  out  1  0 Rd1, 1 shamt
alu_b_sel  out  1  0 Rd2, 1 extended immediate
datasrc  out  2  00 ALU C, 01 DM Dout, 10 PC+4
npc_sel  out  2  00 add4, 01 jump, 10 branch, 11 jr
alu_op  out  3  000 add, 001 sub, 010 or, 011 lui, 100 sll
illegal  out  1  one-cycle pulse on unsupported instruction
mem_timeout  out  1  one-cycle pulse on MEM abort
state  out  3  current state, for debug

Behaviour:
- States (encoding): FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4. Outputs are combinational from state and the latched class register.
- Reset: state is FETCH and the class register is cleared asynchronously. While reset is high, all enables, illegal and mem_timeout are forced to 0 and all selects to 0. A reset during MEM drops dm_we/dm_re in the same cycle with no write back.
- Default output values in every state: enables 0, selects 00/0, alu_op 000.
- FETCH: ir_we=1, pc_we=1, npc_sel=00. Next state DECODE.
- DECODE:
  - Decode instr_op/instr_funct. Latch the class at the clock edge.
  - Supported: R-type (op 000000) addu 100001, subu 100011, sll 000000, jr 001000; ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; j 000010; jal 000011.
  - j: pc_we=1, npc_sel=01, next FETCH (2 cycles total).
  - jr: pc_we=1, npc_sel=11, next FETCH.
  - jal: pc_we=1, npc_sel=01, next WB.
  - Unsupported: illegal=1, no write enables, next FETCH (executes as a NOP).
  - All other supported instructions: next EXEC.
- EXEC:
  - addu alu_op 000; subu 001; sll 100 with alu_a_sel=1; ori 010 with alu_b_sel=1; lui 011 with alu_b_sel=1.
  - lw/sw: alu_op 000, alu_b_sel=1, next MEM.
  - beq: alu_op 001, pc_we=1, npc_sel=10, next FETCH (3 cycles).
  - ALU instructions: next WB.
- MEM:
  - lw holds dm_re=1; sw holds dm_we=1.
  - Both stay in MEM until mem_ready=1.
  - On ready: lw goes to WB, sw goes to FETCH.
  - mem_ready=1 on the first MEM cycle gives zero wait.
  - mem_ready is ignored in all other states.
- WB:
  - rf_we=1.
  - R-type: regdst 00, datasrc 00.
  - ori/lui: regdst 01, datasrc 00.
  - lw: regdst 01, datasrc 01.
  - jal: regdst 10, datasrc 10.
  - Next FETCH.
- Latencies, excluding memory waits: R/ori/lui 4, lw 5, sw 4, beq 3, jal 3, j/jr 2.

Optional Feature:
MC_MEM_TIMEOUT_EN
- Defined:
  - A counter clears on MEM entry and increments each MEM cycle with mem_ready=0.
  - When it reaches TIMEOUT_CYCLES with mem_ready still 0: mem_timeout pulses for 1 cycle, dm_re/dm_we drop, and the FSM goes to FETCH with no WB.
  - mem_ready=1 in that same cycle takes priority: normal completion, no pulse.
  - The counter resets asynchronously.
- Undefined: MEM waits indefinitely; mem_timeout is tied 0; no counter is built.

Test Plan:
- Reset high mid-MEM of sw with dm_we=1 -> dm_we=0 immediately, state=0; after release the next cycle shows ir_we=1, pc_we=1.
- addu (op 0, funct 100001) -> 4 cycles; WB shows rf_we=1, regdst=00, datasrc=00; EXEC shows alu_op=000.
- lw with mem_ready low for 3 MEM cycles -> dm_re high for 4 cycles, then WB with regdst=01, datasrc=01; total 8 cycles.
- jal -> DECODE: pc_we=1, npc_sel=01; WB: rf_we=1, regdst=10, datasrc=10; next is FETCH.
- op 111111 -> illegal pulses in DECODE, no rf_we/dm_we, FETCH follows.
- With MC_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, sw with mem_ready stuck 0 -> mem_timeout pulses after 4 wait cycles, then FETCH; with the macro undefined, the FSM stays in MEM.
